// File: rtl/qspi_pkg.sv
// Shared types and defaults for the quad-SPI SRAM controller.
// HOLD exists only when QSPI_BURST_EN is defined (sequential-read streaming).
package qspi_pkg;

  localparam logic [7:0]  CMD_READ_DEF    = 8'hEB;
  localparam logic [7:0]  CMD_WRITE_DEF   = 8'h38;
  localparam int unsigned WAIT_CYCLES_DEF = 4;

  localparam logic [7:0]  CMD_LAST  = 8'd7;
  localparam logic [7:0]  ADDR_LAST = 8'd5;
  localparam logic [7:0]  DATA_LAST = 8'd1;
  localparam logic [7:0]  READ_LAST = 8'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_READ,
    ST_WRITE
`ifdef QSPI_BURST_EN
    , ST_HOLD
`endif
  } state_e;

endpackage

// File: rtl/qspi_sram_ctrl.sv
// Single-byte quad-SPI (1S-4S-4S) SRAM controller; SCK = clk/2.
// Optional macro QSPI_BURST_EN keeps the device selected after reads for sequential streaming.
module qspi_sram_ctrl
  import qspi_pkg::*;
#(
  parameter logic [7:0]  CMD_READ    = CMD_READ_DEF,
  parameter logic [7:0]  CMD_WRITE   = CMD_WRITE_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic        sck,
  output logic        ss_n,
  output logic [3:0]  sio_out,
  output logic [3:0]  sio_oe,
  input  logic [3:0]  sio_in
);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  lead_q, lead_d;
  logic [39:0] shift_q, shift_d;
  logic        we_q, we_d;
  logic        ready_q, ready_d;
  logic        ss_n_q, ss_n_d;
  logic        sck_q, sck_d;
  logic [3:0]  sio_out_q, sio_out_d;
  logic [3:0]  sio_oe_q, sio_oe_d;
  logic        resp_valid_q, resp_valid_d;
  logic [7:0]  resp_rdata_q, resp_rdata_d;
  logic        accept;
`ifdef QSPI_BURST_EN
  logic [23:0] addr_q, addr_d;
`endif

  assign accept = req_valid && ready_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lead_d       = lead_q;
    shift_d      = shift_q;
    we_d         = we_q;
    ss_n_d       = ss_n_q;
    sck_d        = sck_q;
    sio_out_d    = sio_out_q;
    sio_oe_d     = sio_oe_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
`ifdef QSPI_BURST_EN
    addr_d       = addr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d = {(req_we ? CMD_WRITE : CMD_READ), req_addr, req_wdata};
          we_d    = req_we;
          cnt_d   = CMD_LAST;
          lead_d  = 2'd1;
          state_d = ST_CMD;
`ifdef QSPI_BURST_EN
          addr_d  = req_addr;
`endif
        end
      end
`ifdef QSPI_BURST_EN
      ST_HOLD: begin
        if (accept) begin
          addr_d = req_addr;
          we_d   = req_we;
          if (!req_we && (req_addr == addr_q + 24'd1)) begin
            cnt_d   = DATA_LAST;
            lead_d  = 2'd1;
            state_d = ST_READ;
          end else begin
            // Deselect for two extra cycles before restarting with a full command.
            shift_d = {(req_we ? CMD_WRITE : CMD_READ), req_addr, req_wdata};
            cnt_d   = CMD_LAST;
            lead_d  = 2'd3;
            ss_n_d  = 1'b1;
            state_d = ST_CMD;
          end
        end
      end
`endif
      default: begin
        if (lead_q != 2'd0) begin
          lead_d = lead_q - 2'd1;
          if (lead_q == 2'd1 && state_q == ST_CMD) begin
            ss_n_d    = 1'b0;
            sck_d     = 1'b0;
            sio_out_d = {3'b000, shift_q[39]};
            sio_oe_d  = 4'b0001;
            shift_d   = shift_q << 1;
          end
        end else if (!sck_q) begin
          sck_d = 1'b1;
          if (state_q == ST_READ && cnt_q <= 8'd1) begin
            shift_d = {shift_q[35:0], sio_in};
          end
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
          sck_d = 1'b0;
          if (state_q == ST_CMD) begin
            sio_out_d = {3'b000, shift_q[39]};
            shift_d   = shift_q << 1;
          end else if (state_q == ST_ADDR || state_q == ST_WRITE) begin
            sio_out_d = shift_q[39:36];
            shift_d   = shift_q << 4;
          end
        end else begin
          sck_d = 1'b0;
          case (state_q)
            ST_CMD: begin
              state_d   = ST_ADDR;
              cnt_d     = ADDR_LAST;
              sio_out_d = shift_q[39:36];
              sio_oe_d  = 4'b1111;
              shift_d   = shift_q << 4;
            end
            ST_ADDR: begin
              if (we_q) begin
                state_d   = ST_WRITE;
                cnt_d     = DATA_LAST;
                sio_out_d = shift_q[39:36];
                sio_oe_d  = 4'b1111;
                shift_d   = shift_q << 4;
              end else begin
                sio_out_d = 4'b0000;
                sio_oe_d  = 4'b0000;
                if (WAIT_CYCLES == 0) begin
                  state_d = ST_READ;
                  cnt_d   = READ_LAST;
                end else begin
                  state_d = ST_WAIT;
                  cnt_d   = 8'(WAIT_CYCLES - 1);
                end
              end
            end
            ST_WAIT: begin
              state_d = ST_READ;
              cnt_d   = READ_LAST;
            end
            default: begin
              sio_out_d    = 4'b0000;
              sio_oe_d     = 4'b0000;
              resp_valid_d = 1'b1;
              if (state_q == ST_READ) begin
                resp_rdata_d = shift_q[7:0];
              end
`ifdef QSPI_BURST_EN
              if (state_q == ST_READ) begin
                ss_n_d  = 1'b0;
                state_d = ST_HOLD;
              end else begin
                ss_n_d  = 1'b1;
                state_d = ST_IDLE;
              end
`else
              ss_n_d  = 1'b1;
              state_d = ST_IDLE;
`endif
            end
          endcase
        end
      end
    endcase

`ifdef QSPI_BURST_EN
    ready_d = (state_d == ST_IDLE) || (state_d == ST_HOLD);
`else
    ready_d = (state_d == ST_IDLE);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      lead_q       <= 2'd0;
      shift_q      <= 40'd0;
      we_q         <= 1'b0;
      ready_q      <= 1'b0;
      ss_n_q       <= 1'b1;
      sck_q        <= 1'b0;
      sio_out_q    <= 4'b0000;
      sio_oe_q     <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 8'd0;
`ifdef QSPI_BURST_EN
      addr_q       <= 24'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lead_q       <= lead_d;
      shift_q      <= shift_d;
      we_q         <= we_d;
      ready_q      <= ready_d;
      ss_n_q       <= ss_n_d;
      sck_q        <= sck_d;
      sio_out_q    <= sio_out_d;
      sio_oe_q     <= sio_oe_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef QSPI_BURST_EN
      addr_q       <= addr_d;
`endif
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign sck        = sck_q;
  assign ss_n       = ss_n_q;
  assign sio_out    = sio_out_q;
  assign sio_oe     = sio_oe_q;

endmodule

// File: doc/qspi_sram_ctrl.md
QSPI_SRAM_CTRL -- requirements
Module: qspi_sram_ctrl

Interface
REQ-001 Parameter CMD_READ, default 8'hEB, SHALL be the quad read command (1S-4S-4S).
REQ-002 Parameter CMD_WRITE, default 8'h38, SHALL be the quad write command (1S-4S-4S).
REQ-003 Parameter WAIT_CYCLES, default 4, SHALL be the number of dummy SCK periods between address and read data.
REQ-004 clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 req_valid  in  1  request present; req_ready  out  1  request accepted when both are high at a clk edge.
REQ-007 req_we  in  1  1=write byte, 0=read byte; req_addr  in  24  byte address; req_wdata  in  8  write data.
REQ-008 resp_valid  out  1  one-cycle pulse on completion; resp_rdata  out  8  read byte, valid with resp_valid.
REQ-009 sck  out  1; ss_n  out  1; sio_out  out  4; sio_oe  out  4 (per-bit drive enable); sio_in  in  4.

Function
REQ-010 States SHALL be IDLE, CMD, ADDR, WAIT, READ, WRITE, plus HOLD when QSPI_BURST_EN is defined.
REQ-011 req_ready SHALL be high only in IDLE (and HOLD); requests are captured into internal registers on acceptance.
REQ-012 Each SCK period SHALL be two clk cycles: low phase, then high phase; sck SHALL be 0 whenever ss_n is 1.
REQ-013 sio_out/sio_oe SHALL change only on the clk edge that drives sck low; sio_in SHALL be sampled on the clk edge that drives sck high.
REQ-014 On acceptance, the next edge SHALL drive ss_n=0, sck=0 and the first command bit.
REQ-015 CMD: 8 periods, MSB first on sio_out[0], sio_out[3:1]=0, sio_oe=4'b0001.
REQ-016 ADDR: 6 periods, address nibbles MSB first on sio_out[3:0], sio_oe=4'b1111.
REQ-017 WRITE: 2 periods, wdata[7:4] then wdata[3:0], sio_oe=4'b1111; total 16 periods.
REQ-018 WAIT: WAIT_CYCLES periods, sio_oe=4'b0000; oe SHALL remain 0 through READ.
REQ-019 READ: 3 periods; high nibble sampled at the 2nd rising edge, low nibble at the 3rd; total 8+6+WAIT_CYCLES+3 periods.
REQ-020 On the edge after the final high phase: ss_n=1, sck=0, sio_oe=0, resp_valid=1 (resp_rdata updated for reads, unchanged for writes); state to IDLE.
REQ-021 ss_n SHALL stay high at least 2 clk cycles between transactions.
REQ-022 Read latency (acceptance edge to resp_valid edge) SHALL be 2*(17+WAIT_CYCLES)+1 = 43 cycles at default; write latency 33 cycles.
REQ-023 req_valid while not ready SHALL be ignored with no side effect.

Reset
REQ-024 While rst_n=0: state=IDLE, ss_n=1, sck=0, sio_out=0, sio_oe=0, resp_valid=0, resp_rdata=0, req_ready=0.
REQ-025 Reset mid-transaction SHALL abort it immediately with no resp_valid; req_ready SHALL rise the first cycle after release.

Configuration
REQ-026 Macro QSPI_BURST_EN SHALL enable sequential-read streaming; without it, every transaction is a full deselect-to-deselect cycle per REQ-020.
REQ-027 With QSPI_BURST_EN, read completion SHALL keep ss_n=0, sck=0, enter HOLD and assert resp_valid.
REQ-028 In HOLD, a read with req_addr == last_addr+1 (mod 2^24, 24'hFFFFFF wraps to 0) SHALL clock 2 periods, sampling high then low nibble, with resp_valid 5 cycles after acceptance, staying in HOLD.
REQ-029 In HOLD, any other accepted request SHALL drive ss_n=1 for 2 cycles, then run the full sequence (latency 2 greater than from IDLE).

Structure
REQ-030 Package qspi_pkg SHALL hold the state enum, default command constants and default WAIT_CYCLES.
REQ-031 No sub-module; one period/phase counter and one nibble shift register SHALL serve all states.

Verification (bench uses the QSPI SRAM simulation model, WAIT_CYCLES=4)
REQ-032 Write 8'hA5 to 24'h000010 -> cmd 8'h38 on sio[0], resp_valid 33 cycles after acceptance, model byte 0x10 = 8'hA5.
REQ-033 Read 24'h000010 after REQ-032 -> resp_rdata=8'hA5, resp_valid 43 cycles after acceptance, ss_n high >=2 cycles after.
REQ-034 Back-to-back requests with req_valid held high -> second accepted only after deselect; no overlap of ss_n windows.
REQ-035 Assert rst_n=0 during ADDR -> ss_n=1, sio_oe=0 same cycle; no resp_valid; next read returns correct data.
REQ-036 With QSPI_BURST_EN: reads 24'hFFFFFF then 24'h000000 preloaded 8'h11/8'h22 -> 8'h11 at 43, 8'h22 at 5 cycles; then read 24'h000005 -> deselect, latency 45.
